// File: rtl/gomoku_pkg.sv
// Shared constants for the Gomoku board controller: cell and winner codes,
// FSM states and the four scan directions.
package gomoku_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    // Winner codes share their encoding with the mover's cell code.
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_BLACK = 2'b01;
    localparam logic [1:0] WIN_WHITE = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Positive-ray deltas for E-W, S-N, SE-NW, SW-NE; the negative ray mirrors them.
    localparam int NDIR = 4;
    localparam logic signed [1:0] DROW [NDIR] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
    localparam logic signed [1:0] DCOL [NDIR] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

endpackage

// File: rtl/gomoku_board_ctrl_if.sv
// Button inputs and board/status outputs of the board controller.
interface gomoku_board_ctrl_if #(
    parameter int N = 10
);
    localparam int PW  = $clog2(N*N);
    localparam int MCW = $clog2(N*N+1);

    logic             left, right, up, down, put, undo;
    logic [PW-1:0]    cursor_pos;
    logic [N*N-1:0]   board_black, board_white;
    logic             turn, busy, reject, game_over;
    logic [1:0]       winner;
    logic [MCW-1:0]   move_count;

    modport master (
        output left, right, up, down, put, undo,
        input  cursor_pos, board_black, board_white, turn, busy, reject,
               winner, game_over, move_count
    );

    modport slave (
        input  left, right, up, down, put, undo,
        output cursor_pos, board_black, board_white, turn, busy, reject,
               winner, game_over, move_count
    );
endinterface

// File: rtl/gomoku_history.sv
// Move history: LIFO on a ring of DEPTH entries; a push when full drops the oldest.
module gomoku_history #(
    parameter int DEPTH = 16,
    parameter int PW    = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PW-1:0]                din,
    output logic [PW-1:0]                dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_top;

    assign w_top = r_wp - AW'(1);
    assign dout  = r_mem[w_top];
    assign empty = (r_cnt == '0);
    assign count = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_wp <= r_wp + AW'(1);
            if (r_cnt != CW'(DEPTH)) r_cnt <= r_cnt + CW'(1);
        end else if (pop && !empty) begin
            r_wp  <= w_top;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/gomoku_board_ctrl.sv
// Two-player Gomoku board controller: cursor, turn alternation, undo history and
// a fixed-latency five-in-a-row scan after every placement.
module gomoku_board_ctrl
    import gomoku_pkg::*;
#(
    parameter int N          = 10,
    parameter int WIN_LEN    = 5,
    parameter int UNDO_DEPTH = 16
) (
    input logic                clk,
    input logic                rst,
    gomoku_board_ctrl_if.slave bus
);
    localparam int PW  = $clog2(N*N);
    localparam int MCW = $clog2(N*N+1);
    localparam int SW  = PW + 1;
    localparam int HCW = $clog2(UNDO_DEPTH+1);
    localparam logic [PW-1:0]         NP      = PW'(N);
    localparam logic [PW-1:0]         NM1     = PW'(N-1);
    localparam logic [PW-1:0]         CUR_RST = PW'(((N-1)/2)*N + (N-1)/2);
    localparam logic signed [SW-1:0]  NS      = SW'(N);
    localparam logic [SW-1:0]         KLAST   = SW'(WIN_LEN-1);
    localparam logic [SW-1:0]         WLEN    = SW'(WIN_LEN);
    localparam logic [MCW-1:0]        CELLS   = MCW'(N*N);

    state_t                r_state;
    logic [5:0]            r_prev;
    logic [PW-1:0]         r_cursor;
    logic [N*N-1:0]        r_board_black, r_board_white;
    logic                  r_turn, r_reject, r_neg, r_alive, r_found;
    logic [1:0]            r_winner, r_dir;
    logic [MCW-1:0]        r_mcnt;
    logic signed [SW-1:0]  r_org_row, r_org_col, r_k;
    logic [SW-1:0]         r_cnt;

    logic [5:0]            w_btn, w_ev;
    logic [PW-1:0]         w_row, w_col, w_cur_mv, w_pidx, w_hist_dout;
    logic signed [SW-1:0]  w_off, w_dr, w_dc, w_prow, w_pcol;
    logic [SW-1:0]         w_cnt_nx;
    logic [1:0]            w_mover;
    logic [HCW-1:0]        w_hist_cnt;
    logic                  w_inb, w_hit, w_occ, w_push, w_pop, w_hist_empty, w_found_dir;

    // Button order: right, left, up, down, put, undo.
    assign w_btn = {bus.undo, bus.put, bus.down, bus.up, bus.left, bus.right};
    assign w_ev  = w_btn & ~r_prev;
    assign w_row = r_cursor / NP;
    assign w_col = r_cursor % NP;

    always_comb begin
        w_cur_mv = r_cursor;
        if (w_ev[0])      begin if (w_col != NM1) w_cur_mv = r_cursor + PW'(1); end
        else if (w_ev[1]) begin if (w_col != '0)  w_cur_mv = r_cursor - PW'(1); end
        else if (w_ev[2]) begin if (w_row != '0)  w_cur_mv = r_cursor - NP;     end
        else if (w_ev[3]) begin if (w_row != NM1) w_cur_mv = r_cursor + NP;     end
    end

    assign w_occ  = r_board_black[r_cursor] | r_board_white[r_cursor];
    assign w_pop  = (r_state != ST_SCAN) && w_ev[5] && !w_hist_empty && (w_hist_cnt != '0);
    assign w_push = (r_state == ST_IDLE) && !w_ev[5] && w_ev[4] && !w_occ;

    // Probe cell: origin + k*delta on the current ray, stepped in row/col space.
    assign w_off = r_neg ? -r_k : r_k;
    always_comb begin
        w_dr = '0;
        w_dc = '0;
        if (DROW[r_dir] == 2'sd1) w_dr = w_off; else if (DROW[r_dir] == -2'sd1) w_dr = -w_off;
        if (DCOL[r_dir] == 2'sd1) w_dc = w_off; else if (DCOL[r_dir] == -2'sd1) w_dc = -w_off;
    end
    assign w_prow      = r_org_row + w_dr;
    assign w_pcol      = r_org_col + w_dc;
    assign w_inb       = !w_prow[SW-1] && !w_pcol[SW-1] && (w_prow < NS) && (w_pcol < NS);
    assign w_pidx      = w_inb ? (w_prow[PW-1:0] * NP + w_pcol[PW-1:0]) : '0;
    assign w_mover     = r_turn ? CELL_WHITE : CELL_BLACK;
    assign w_hit       = w_inb && ({r_board_white[w_pidx], r_board_black[w_pidx]} == w_mover);
    assign w_cnt_nx    = r_cnt + SW'(r_alive && w_hit);
    assign w_found_dir = (w_cnt_nx + SW'(1)) >= WLEN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;  r_prev <= '0;  r_cursor <= CUR_RST;
            r_board_black <= '0; r_board_white <= '0;
            r_turn <= 1'b0;  r_reject <= 1'b0;  r_winner <= WIN_NONE;  r_mcnt <= '0;
            r_org_row <= '0; r_org_col <= '0;   r_k <= '0;  r_cnt <= '0;
            r_dir <= '0;     r_neg <= 1'b0;     r_alive <= 1'b0;  r_found <= 1'b0;
        end else begin
            r_prev   <= w_btn;
            r_reject <= 1'b0;
            r_cursor <= w_cur_mv;
            if (w_pop) begin
                // The popped stone's colour is whoever moves next.
                r_board_black[w_hist_dout] <= 1'b0;
                r_board_white[w_hist_dout] <= 1'b0;
                r_turn   <= r_board_white[w_hist_dout];
                r_mcnt   <= r_mcnt - MCW'(1);
                r_cursor <= w_hist_dout;
                r_winner <= WIN_NONE;
                r_state  <= ST_IDLE;
            end else if (r_state == ST_IDLE && !w_ev[5] && w_ev[4]) begin
                if (w_occ) begin
                    r_reject <= 1'b1;
                end else begin
                    if (r_turn) r_board_white[r_cursor] <= 1'b1;
                    else        r_board_black[r_cursor] <= 1'b1;
                    r_mcnt    <= r_mcnt + MCW'(1);
                    r_org_row <= SW'(w_row);
                    r_org_col <= SW'(w_col);
                    r_k <= SW'(1);  r_dir <= '0;  r_neg <= 1'b0;
                    r_cnt <= '0;    r_alive <= 1'b1;  r_found <= 1'b0;
                    r_state <= ST_SCAN;
                end
            end else if (r_state == ST_SCAN) begin
                r_k     <= r_k + SW'(1);
                r_cnt   <= w_cnt_nx;
                r_alive <= r_alive && w_hit;
                if (r_k == KLAST) begin
                    r_k     <= SW'(1);
                    r_alive <= 1'b1;
                    r_neg   <= ~r_neg;
                    if (r_neg) begin
                        r_cnt   <= '0;
                        r_dir   <= r_dir + 2'd1;
                        r_found <= r_found | w_found_dir;
                        if (r_dir == 2'd3) begin
                            if (r_found || w_found_dir) begin
                                r_winner <= w_mover;
                                r_state  <= ST_DONE;
                            end else if (r_mcnt == CELLS) begin
                                r_winner <= WIN_DRAW;
                                r_state  <= ST_DONE;
                            end else begin
                                r_turn  <= ~r_turn;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
            end
        end
    end

    gomoku_history #(.DEPTH(UNDO_DEPTH), .PW(PW)) u_hist (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_cursor),
        .dout  (w_hist_dout),
        .empty (w_hist_empty),
        .count (w_hist_cnt)
    );

    assign bus.cursor_pos  = r_cursor;
    assign bus.board_black = r_board_black;
    assign bus.board_white = r_board_white;
    assign bus.turn        = r_turn;
    assign bus.busy        = (r_state == ST_SCAN);
    assign bus.reject      = r_reject;
    assign bus.winner      = r_winner;
    assign bus.game_over   = (r_winner != WIN_NONE);
    assign bus.move_count  = r_mcnt;

endmodule

// File: tb/tb_gomoku_board_ctrl.sv
// Directed bench for gomoku_board_ctrl: cursor, put/reject, win, undo, history
// depth, row-wrap immunity and reset mid-scan.
module tb_gomoku_board_ctrl;
    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] btn = '0;
    int         n_chk = 0;
    int         n_bad = 0;
    int         bc;
    logic [127:0] eb, ew;

    always #5 clk = ~clk;

    gomoku_board_ctrl_if #(.N(N)) bus ();
    assign bus.right = btn[0];
    assign bus.left  = btn[1];
    assign bus.up    = btn[2];
    assign bus.down  = btn[3];
    assign bus.put   = btn[4];
    assign bus.undo  = btn[5];

    gomoku_board_ctrl #(.N(N), .WIN_LEN(5), .UNDO_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] bit_at(input int p);
        logic [127:0] one;
        one = 128'd1;
        return one << p;
    endfunction

    task automatic do_reset();
        btn = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input int b);
        @(negedge clk);
        btn[b] = 1'b1;
        @(negedge clk);
        btn = '0;
    endtask

    task automatic goto(input int t);
        int cr, cc;
        for (int i = 0; i < 40 && int'(bus.cursor_pos) != t; i++) begin
            cr = int'(bus.cursor_pos) / N;
            cc = int'(bus.cursor_pos) % N;
            if (t % N > cc)      press(0);
            else if (t % N < cc) press(1);
            else if (t / N < cr) press(2);
            else                 press(3);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic place(input int t, output int n);
        goto(t);
        press(4);
        wait_idle(n);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cur"},  bus.cursor_pos, 44);
        chk({tag, "_blk"},  bus.board_black, 0);
        chk({tag, "_wht"},  bus.board_white, 0);
        chk({tag, "_turn"}, bus.turn, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rej"},  bus.reject, 0);
        chk({tag, "_win"},  bus.winner, 0);
        chk({tag, "_go"},   bus.game_over, 0);
        chk({tag, "_mc"},   bus.move_count, 0);
    endtask

    initial begin
        do_reset();
        chk_reset_vals("rst");

        // Cursor moves and edge clamping
        press(0); press(0); press(0); press(3);
        chk("cur_r3d1", bus.cursor_pos, 57);
        goto(50);
        press(1);
        chk("cur_left_edge", bus.cursor_pos, 50);
        goto(59);
        press(0);
        chk("cur_right_edge", bus.cursor_pos, 59);
        goto(9);
        press(2);
        chk("cur_top_edge", bus.cursor_pos, 9);

        // Put, busy length, then reject on the same cell
        do_reset();
        place(44, bc);
        chk("busy_len", bc, 32);
        chk("put_blk", bus.board_black, bit_at(44));
        chk("put_turn", bus.turn, 1);
        chk("put_mc", bus.move_count, 1);
        press(4);
        chk("rej_pulse", bus.reject, 1);
        chk("rej_busy", bus.busy, 0);
        @(negedge clk);
        chk("rej_clear", bus.reject, 0);
        chk("rej_blk", bus.board_black, bit_at(44));
        chk("rej_wht", bus.board_white, 0);
        chk("rej_mc", bus.move_count, 1);

        // Horizontal five for black
        do_reset();
        place(40, bc); place(50, bc); place(41, bc); place(51, bc);
        place(42, bc); place(52, bc); place(43, bc); place(53, bc);
        chk("pre_win", bus.winner, 0);
        place(44, bc);
        chk("win_busy_len", bc, 32);
        chk("win_code", bus.winner, 1);
        chk("win_go", bus.game_over, 1);
        chk("win_turn", bus.turn, 0);
        goto(60);
        press(4);
        @(negedge clk);
        chk("done_put_blk", bus.board_black[60], 0);
        chk("done_put_mc", bus.move_count, 9);
        chk("done_put_busy", bus.busy, 0);
        press(5);
        eb = bit_at(40) | bit_at(41) | bit_at(42) | bit_at(43);
        chk("undo_blk", bus.board_black, eb);
        chk("undo_win", bus.winner, 0);
        chk("undo_go", bus.game_over, 0);
        chk("undo_turn", bus.turn, 0);
        chk("undo_cur", bus.cursor_pos, 44);
        chk("undo_mc", bus.move_count, 8);
        // Undo pressed while busy is dropped
        press(4);
        press(5);
        wait_idle(bc);
        chk("busy_undo_blk", bus.board_black, eb | bit_at(44));
        chk("busy_undo_win", bus.winner, 1);
        chk("busy_undo_mc", bus.move_count, 9);

        // 17 puts overflow a 16-deep history
        do_reset();
        for (int p = 0; p < 17; p++) place(p, bc);
        chk("h17_mc", bus.move_count, 17);
        chk("h17_turn", bus.turn, 1);
        for (int u = 0; u < 16; u++) press(5);
        chk("h16_mc", bus.move_count, 1);
        chk("h16_blk", bus.board_black, bit_at(0));
        chk("h16_wht", bus.board_white, 0);
        chk("h16_cur", bus.cursor_pos, 1);
        chk("h16_turn", bus.turn, 1);
        press(5);
        chk("h17u_mc", bus.move_count, 1);
        chk("h17u_blk", bus.board_black, bit_at(0));
        chk("h17u_cur", bus.cursor_pos, 1);

        // SE run ending at the right edge must not continue across the row wrap
        do_reset();
        place(6, bc);  place(90, bc); place(17, bc); place(92, bc);
        place(28, bc); place(94, bc); place(39, bc); place(96, bc);
        place(40, bc);
        chk("wrap_ew_win", bus.winner, 0);
        place(98, bc);
        place(50, bc);
        chk("wrap_se_win", bus.winner, 0);
        chk("wrap_turn", bus.turn, 1);
        chk("wrap_mc", bus.move_count, 11);
        ew = bit_at(90) | bit_at(92) | bit_at(94) | bit_at(96) | bit_at(98);
        chk("wrap_wht", bus.board_white, ew);

        // Reset in the middle of a scan
        goto(99);
        press(4);
        repeat (5) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("async_busy", bus.busy, 0);
        chk("async_cur", bus.cursor_pos, 44);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        press(5);
        chk("empty_undo_mc", bus.move_count, 0);
        chk("empty_undo_blk", bus.board_black, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
